// File: rtl/ov5640_tx_pkg.sv
// ov5640_tx_pkg: shared state encoding, byte order and line-length helper for the DVP transmitter.
package ov5640_tx_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VFRONT, ACTIVE, VBACK} tx_state_e;
  localparam bit HI_FIRST = 1'b1;
  function automatic int line_clks(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction
endpackage

// File: rtl/ov5640_tx_timing.sv
// ov5640_tx_timing: frame/line sequencer producing the unregistered DVP phase flags.
module ov5640_tx_timing
  import ov5640_tx_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 160,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_LEN = 4,
  parameter int V_FRONT   = 2,
  parameter int V_BACK    = 2
) (
  input  logic ov5640_pclk,
  input  logic sys_rst_n,
  input  logic i_enable,
  output logic o_active_slot,
  output logic o_vsync_phase,
  output logic o_href_phase,
  output logic o_frame_end
);
  localparam int LINE_CLKS = line_clks(H_ACTIVE, H_BLANK);
  localparam int HW = LINE_CLKS > 1 ? $clog2(LINE_CLKS) : 1;
  localparam int VMAX1 = VSYNC_LEN > V_FRONT ? VSYNC_LEN : V_FRONT;
  localparam int VMAX2 = V_ACTIVE > V_BACK ? V_ACTIVE : V_BACK;
  localparam int VMAX = VMAX1 > VMAX2 ? VMAX1 : VMAX2;
  localparam int VW = VMAX > 1 ? $clog2(VMAX) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(LINE_CLKS - 1);
  localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);
  tx_state_e r_state, w_after;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt, w_len_m1;
  logic w_line_end, w_state_last;
  assign w_line_end = r_h_cnt == H_LAST;
  assign w_state_last = w_line_end && r_v_cnt == w_len_m1;
  // Zero-length front/back porches are skipped when choosing the successor state.
  always_comb begin
    w_len_m1 = r_state == VSYNC  ? VW'(VSYNC_LEN - 1) :
               r_state == VFRONT ? VW'(V_FRONT - 1) :
               r_state == ACTIVE ? VW'(V_ACTIVE - 1) : VW'(V_BACK - 1);
    w_after = r_state == VSYNC  ? (V_FRONT > 0 ? VFRONT : ACTIVE) :
              r_state == VFRONT ? ACTIVE :
              (r_state == ACTIVE && V_BACK > 0) ? VBACK :
              i_enable ? VSYNC : IDLE;
  end
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (i_enable) r_state <= VSYNC;
    end else begin
      r_h_cnt <= w_line_end ? '0 : r_h_cnt + 1'b1;
      if (w_line_end) r_v_cnt <= w_state_last ? '0 : r_v_cnt + 1'b1;
      if (w_state_last) r_state <= w_after;
    end
  end
  assign o_vsync_phase = r_state == VSYNC;
  assign o_href_phase = r_state == ACTIVE && r_h_cnt < H_HREF;
  assign o_active_slot = o_href_phase && !r_h_cnt[0];
  assign o_frame_end = w_state_last && (r_state == VBACK || (V_BACK == 0 && r_state == ACTIVE));
endmodule

// File: rtl/ov5640_dvp_tx.sv
// ov5640_dvp_tx: OV5640-style DVP transmitter serialising RGB565 pixels onto an 8-bit vsync/href bus.
module ov5640_dvp_tx
  import ov5640_tx_pkg::*;
#(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_BLANK   = 160,
  parameter int          V_ACTIVE  = 480,
  parameter int          VSYNC_LEN = 4,
  parameter int          V_FRONT   = 2,
  parameter int          V_BACK    = 2,
  parameter logic [15:0] FILL_PIX  = 16'h0000
) (
  input  logic        ov5640_pclk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        underrun
);
  logic w_active_slot, w_vsync_phase, w_href_phase, w_frame_end;
  logic [15:0] w_pix, r_hold_pix;
  logic [7:0] w_first, w_second;
  ov5640_tx_timing #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LEN(VSYNC_LEN), .V_FRONT(V_FRONT), .V_BACK(V_BACK)
  ) u_timing (
    .ov5640_pclk  (ov5640_pclk),
    .sys_rst_n    (sys_rst_n),
    .i_enable     (enable),
    .o_active_slot(w_active_slot),
    .o_vsync_phase(w_vsync_phase),
    .o_href_phase (w_href_phase),
    .o_frame_end  (w_frame_end)
  );
  assign pix_ready = w_active_slot;
  assign w_pix = pix_valid ? pix_data : FILL_PIX;
  // The first byte goes straight from the input so it lands in the cycle after sampling.
  assign w_first = HI_FIRST ? w_pix[15:8] : w_pix[7:0];
  assign w_second = HI_FIRST ? r_hold_pix[7:0] : r_hold_pix[15:8];
  always_ff @(posedge ov5640_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      r_hold_pix <= '0;
    end else begin
      cam_vsync  <= w_vsync_phase;
      cam_href   <= w_href_phase;
      cam_data   <= w_active_slot ? w_first : w_href_phase ? w_second : 8'h00;
      frame_done <= w_frame_end;
      if (w_active_slot) begin
        r_hold_pix <= w_pix;
        if (!pix_valid) underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// tb_ov5640_dvp_tx: directed/random bench comparing the DVP transmitter against a frame-position model.
module tb_ov5640_dvp_tx;
  localparam int HA = 4, HB = 3, VA = 2, VS = 1, VF = 1, VB = 1;
  localparam int LINE = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VF + VA + VB);
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pix_valid = 1'b1;
  logic [15:0] pix_data = 16'hA1B2;
  logic pix_ready, cam_vsync, cam_href, frame_done, underrun;
  logic [7:0] cam_data;
  int n_asserts = 0, n_fail = 0;
  int ph = -1, slot_cnt = 0, drop_slot = 2, pix_n = 0;
  int vs_cnt = 0, hr_cnt = 0, done_cnt = 0;
  bit exp_unr = 0, have_hi = 0;
  logic [15:0] last_pix = '0;
  logic [7:0] rx_hi;
  logic [15:0] exp_q[$];

  ov5640_dvp_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LEN(VS), .V_FRONT(VF), .V_BACK(VB), .FILL_PIX(16'h0000)
  ) dut (
    .ov5640_pclk(clk), .sys_rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_vs(input int p);
    return p >= 0 && p < VS * LINE;
  endfunction
  function automatic bit m_href(input int p);
    int line = p / LINE;
    return p >= 0 && line >= VS + VF && line < VS + VF + VA && (p % LINE) < 2 * HA;
  endfunction
  function automatic bit m_rdy(input int p);
    return m_href(p) && (p % LINE) % 2 == 0;
  endfunction

  task automatic step();
    bit rdy, acc;
    int pb;
    logic [15:0] smp, word;
    rdy = m_rdy(ph);
    pix_valid = rdy ? (slot_cnt != drop_slot) : 1'($urandom);
    chk("pix_ready", {31'b0, pix_ready}, {31'b0, rdy});
    if (rdy) begin
      smp = pix_valid ? pix_data : 16'h0000;
      if (!pix_valid) exp_unr = 1;
      exp_q.push_back(smp);
      last_pix = smp;
      slot_cnt++;
    end
    acc = rdy && pix_valid;
    pb = ph;
    @(posedge clk);
    #1;
    chk("cam_vsync", {31'b0, cam_vsync}, {31'b0, m_vs(pb)});
    chk("cam_href", {31'b0, cam_href}, {31'b0, m_href(pb)});
    chk("cam_data", {24'b0, cam_data},
        !m_href(pb) ? 32'h0 : ((pb % LINE) % 2 == 0 ? {24'b0, last_pix[15:8]} : {24'b0, last_pix[7:0]}));
    chk("frame_done", {31'b0, frame_done}, {31'b0, pb == FRAME - 1});
    chk("underrun", {31'b0, underrun}, {31'b0, exp_unr});
    if (cam_href) begin
      if (have_hi) begin
        word = {rx_hi, cam_data};
        chk("rx_word", {16'b0, word}, exp_q.size() > 0 ? {16'b0, exp_q.pop_front()} : 32'hDEAD_BEEF);
        have_hi = 0;
      end else begin
        rx_hi = cam_data;
        have_hi = 1;
      end
    end
    if (cam_vsync) vs_cnt++;
    if (cam_href) hr_cnt++;
    if (frame_done) done_cnt++;
    ph = (ph == -1 || ph == FRAME - 1) ? (enable ? 0 : -1) : ph + 1;
    if (acc) begin
      pix_n++;
      pix_data = pix_n == 1 ? 16'hC3D4 : 16'($urandom);
    end
  endtask

  initial begin
    #3;
    chk("rst_vsync", {31'b0, cam_vsync}, 32'h0);
    chk("rst_href", {31'b0, cam_href}, 32'h0);
    chk("rst_data", {24'b0, cam_data}, 32'h0);
    chk("rst_done", {31'b0, frame_done}, 32'h0);
    chk("rst_underrun", {31'b0, underrun}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step();
    enable = 1'b1;
    step();
    vs_cnt = 0; hr_cnt = 0; done_cnt = 0;
    repeat (FRAME) step();
    chk("frame1_vsync_cycles", vs_cnt, VS * LINE);
    chk("frame1_href_cycles", hr_cnt, VA * 2 * HA);
    chk("frame1_done_pulses", done_cnt, 1);
    repeat (2 * FRAME) step();
    chk("three_frame_done_pulses", done_cnt, 3);
    chk("underrun_sticky", {31'b0, underrun}, 32'h1);
    for (int i = 0; i < 2 * FRAME && ph != 27; i++) step();
    chk("reach_active_mid", ph, 27);
    enable = 1'b0;
    done_cnt = 0;
    repeat (FRAME) step();
    chk("disable_frame_done", done_cnt, 1);
    chk("disable_idle", ph, -1);
    enable = 1'b1;
    vs_cnt = 0;
    repeat (30) step();
    chk("restart_vsync_cycles", vs_cnt, VS * LINE);
    for (int i = 0; i < 2 * FRAME && ph != 25; i++) step();
    chk("reach_href_mid", ph, 25);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_vsync", {31'b0, cam_vsync}, 32'h0);
    chk("async_rst_href", {31'b0, cam_href}, 32'h0);
    chk("async_rst_data", {24'b0, cam_data}, 32'h0);
    chk("async_rst_underrun", {31'b0, underrun}, 32'h0);
    chk("async_rst_ready", {31'b0, pix_ready}, 32'h0);
    ph = -1; exp_unr = 0; have_hi = 0; exp_q.delete();
    @(posedge clk);
    #1;
    chk("rst_held_href", {31'b0, cam_href}, 32'h0);
    rst_n = 1'b1;
    vs_cnt = 0;
    repeat (10) step();
    chk("no_vsync_before_enable", vs_cnt, 0);
    enable = 1'b1;
    done_cnt = 0;
    repeat (FRAME + 1) step();
    chk("post_reset_vsync_cycles", vs_cnt, VS * LINE);
    chk("post_reset_done", done_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
